// File: rtl/pipe_ctrl_gen.sv
// pipe_ctrl_gen: hold/flush controller for an NSTAGE in-order pipeline.
// Stage 0 is PC/IF (youngest); stage NSTAGE-1 is the oldest.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   hold_req[i]       stage i cannot advance this cycle
//   flush_req[i]      stage i redirects; all younger stages are wrong-path
//   int_flush         interrupt entry, clears the whole pipeline
//   halt_req          debug halt request (level)
//   hold_flag[k]      pipeline register k keeps its contents
//   clear_flag[k]     pipeline register k loads a bubble
//   halted            pipeline drained and frozen (registered)
//   stall_timeout     hold_req stuck for 2^WDT_W-1 consecutive cycles
module pipe_ctrl_gen #(
  parameter int unsigned NSTAGE       = 4,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned WDT_W        = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NSTAGE-1:0] hold_req,
  input  logic [NSTAGE-1:0] flush_req,
  input  logic              int_flush,
  input  logic              halt_req,
  output logic [NSTAGE-1:0] hold_flag,
  output logic [NSTAGE-1:0] clear_flag,
  output logic              halted,
  output logic              stall_timeout
);

  localparam int unsigned FW = $clog2(FLUSH_CYCLES + 1);
  localparam int unsigned DW = $clog2(NSTAGE + 1);
  localparam logic [WDT_W-1:0] WMAX = '1;
  localparam logic [WDT_W-1:0] WPRE = WMAX - 1'b1;

  typedef enum logic [1:0] {RUN, FLUSH, DRAIN, HALT} state_e;

  state_e            state_q, state_d;
  logic [FW-1:0]     fcnt_q, fcnt_d;
  logic [DW-1:0]     dcnt_q, dcnt_d;
  logic [WDT_W-1:0]  wcnt_q, wcnt_d;
  logic              to_q, to_d;
  logic              halted_q, halted_d;

  logic              flush_any, hold_any;
  logic [NSTAGE-1:0] hmask, fmask, hbub;

  assign flush_any = (|flush_req) | int_flush;
  assign hold_any  = |hold_req;

  // Smear the request vectors downward: hmask covers stages 0..h, fmask
  // covers stages below f. The top bit of hmask, shifted up, is the bubble.
  always_comb begin
    logic [NSTAGE-1:0] fs;
    hmask = hold_req;
    fs    = flush_req;
    for (int unsigned i = 0; i < NSTAGE; i++) begin
      hmask = hmask | (hmask >> 1);
      fs    = fs | (fs >> 1);
    end
    fmask = fs >> 1;
    hbub  = (hmask & ~(hmask >> 1)) << 1;
  end

  always_comb begin
    state_d  = state_q;
    fcnt_d   = fcnt_q;
    dcnt_d   = dcnt_q;
    wcnt_d   = wcnt_q;
    to_d     = to_q;
    halted_d = (state_q == HALT) && halt_req;

    unique case (state_q)
      RUN: begin
        if (flush_any && (FLUSH_CYCLES > 1)) begin
          state_d = FLUSH;
          fcnt_d  = FW'(FLUSH_CYCLES - 1);
        end else if (halt_req) begin
          state_d = DRAIN;
          dcnt_d  = DW'(NSTAGE - 1);
        end
      end
      FLUSH: begin
        if (flush_any) begin
          fcnt_d = FW'(FLUSH_CYCLES - 1);
        end else if (fcnt_q <= FW'(1)) begin
          fcnt_d = '0;
          if (halt_req) begin
            state_d = DRAIN;
            dcnt_d  = DW'(NSTAGE - 1);
          end else begin
            state_d = RUN;
          end
        end else begin
          fcnt_d = fcnt_q - 1'b1;
        end
      end
      DRAIN: begin
        if (!halt_req) begin
          state_d = RUN;
        end else if (!hold_any && !flush_any) begin
          // Only hazard-free cycles push a bubble further toward retirement.
          if (dcnt_q <= DW'(1)) begin
            state_d = HALT;
            dcnt_d  = '0;
          end else begin
            dcnt_d = dcnt_q - 1'b1;
          end
        end
      end
      HALT: begin
        if (!halt_req) state_d = RUN;
      end
      default: state_d = RUN;
    endcase

    if (state_q != HALT) begin
      if (hold_any) begin
        wcnt_d = (wcnt_q == WMAX) ? WMAX : wcnt_q + 1'b1;
        to_d   = (wcnt_d == WMAX);
      end else begin
        wcnt_d = '0;
        to_d   = 1'b0;
      end
    end
  end

  always_comb begin
    hold_flag  = '0;
    clear_flag = '0;
    if (!rst) begin
      if (state_q == HALT) begin
        hold_flag = '1;
      end else begin
        hold_flag  = hmask;
        clear_flag = hbub | fmask;
        if (int_flush) clear_flag = '1;
        if (state_q == FLUSH) clear_flag = clear_flag | NSTAGE'(1);
        if (state_q == DRAIN) begin
          hold_flag  = hold_flag  | NSTAGE'(1);
          clear_flag = clear_flag | NSTAGE'(2);
        end
        hold_flag = hold_flag & ~clear_flag;
      end
    end
  end

  assign halted        = halted_q & ~rst;
  // Asserted in the cycle the count completes, then held by to_q.
  assign stall_timeout = ~rst & (to_q | ((state_q != HALT) && hold_any && (wcnt_q == WPRE)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      fcnt_q   <= '0;
      dcnt_q   <= '0;
      wcnt_q   <= '0;
      to_q     <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      fcnt_q   <= fcnt_d;
      dcnt_q   <= dcnt_d;
      wcnt_q   <= wcnt_d;
      to_q     <= to_d;
      halted_q <= halted_d;
    end
  end

endmodule
